// File: rtl/alu_sumrest_ctrl.sv
// Sequencer owning a shared add/subtract unit: ADD/SUB/CMP in one pass, unsigned MUL by shift-add.
// Latency 2 cycles (ADD/SUB/CMP) or W+1 cycles (MUL) from accepted START to DONE; START ignored while busy.
module alu_sumrest_ctrl #(
    parameter int W = 6
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           START,
    input  logic [1:0]     OP,
    input  logic [W-1:0]   OPA,
    input  logic [W-1:0]   OPB,
    output logic           BUSY,
    output logic           DONE,
    output logic [2*W-1:0] RES,
    output logic [3:0]     FLAGS,
    output logic           ADD_SEL,
    output logic [W-1:0]   ADD_A,
    output logic [W-1:0]   ADD_B,
    input  logic [W-1:0]   ADD_Y,
    input  logic           ADD_COUT
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_CMP = 2'b11;

    logic [1:0]    state;
    logic [1:0]    op_r;
    logic [W-1:0]  opa_r;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;   // holds OPB for single-pass ops, low product half during MUL
    logic [CW-1:0] cnt;

    logic [W-1:0]  bop;
    logic          exec_v;
    logic [W-1:0]  hi_nxt;
    logic [W-1:0]  lo_nxt;

    assign BUSY = (state != S_IDLE);
    assign DONE = (state == S_DONE);

    always_comb begin
        ADD_SEL = 1'b0;
        ADD_A   = '0;
        ADD_B   = '0;
        case (state)
            S_EXEC: begin
                ADD_SEL = op_r[0];
                ADD_A   = opa_r;
                ADD_B   = lo;
            end
            S_MUL: begin
                ADD_A = hi;
                ADD_B = lo[0] ? opa_r : '0;
            end
            default: ;
        endcase
    end

    // Signed overflow uses the operand the adder effectively added (inverted B on subtract).
    assign bop    = op_r[0] ? ~lo : lo;
    assign exec_v = (opa_r[W-1] == bop[W-1]) && (ADD_Y[W-1] != opa_r[W-1]);

    // One shift-add step: {carry, sum, lo} shifted right by one.
    assign hi_nxt = {ADD_COUT & lo[0], ADD_Y[W-1:1]};
    assign lo_nxt = {ADD_Y[0], lo[W-1:1]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            op_r  <= '0;
            opa_r <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            RES   <= '0;
            FLAGS <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        op_r  <= OP;
                        opa_r <= OPA;
                        lo    <= OPB;
                        hi    <= '0;
                        cnt   <= '0;
                        state <= (OP == OP_MUL) ? S_MUL : S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (op_r != OP_CMP) begin
                        RES <= {{W{1'b0}}, ADD_Y};
                    end
                    FLAGS <= {(ADD_Y == '0), ADD_Y[W-1], ADD_COUT, exec_v};
                    state <= S_DONE;
                end
                S_MUL: begin
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        RES   <= {hi_nxt, lo_nxt};
                        FLAGS <= {({hi_nxt, lo_nxt} == '0), 1'b0, 1'b0, (hi_nxt != '0)};
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sumrest_ctrl.sv
// Randomized and directed bench for alu_sumrest_ctrl with an arithmetic reference model and an adder model.
module tb_alu_sumrest_ctrl;
    localparam int W = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [1:0]     op_i;
    logic [W-1:0]   opa;
    logic [W-1:0]   opb;
    logic           busy;
    logic           done;
    logic [2*W-1:0] res;
    logic [3:0]     flags;
    logic           add_sel;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W-1:0]   add_y;
    logic           add_cout;

    int checks = 0;
    int errors = 0;

    logic [2*W-1:0] exp_res;
    logic [3:0]     exp_flags;

    always #5 clk = ~clk;

    alu_sumrest_ctrl #(.W(W)) dut (
        .CLK(clk), .RST(rst), .START(start), .OP(op_i), .OPA(opa), .OPB(opb),
        .BUSY(busy), .DONE(done), .RES(res), .FLAGS(flags),
        .ADD_SEL(add_sel), .ADD_A(add_a), .ADD_B(add_b),
        .ADD_Y(add_y), .ADD_COUT(add_cout)
    );

    // Shared adder: Y = A + B (SEL=0) or A + ~B + 1 (SEL=1).
    logic [W:0] sum;
    always_comb begin
        sum      = {1'b0, add_a} + {1'b0, (add_sel ? ~add_b : add_b)} + {{W{1'b0}}, add_sel};
        add_y    = sum[W-1:0];
        add_cout = sum[W];
    end

    // Reference model in plain integer arithmetic.
    task automatic model(input logic [1:0] op, input int a, input int b);
        int sa, sb, r, y;
        logic z, n, c, v;
        sa = (a >= 32) ? a - 64 : a;
        sb = (b >= 32) ? b - 64 : b;
        if (op == 2'b10) begin
            r = a * b;
            exp_res   = 12'(r);
            exp_flags = {(r == 0), 1'b0, 1'b0, (r >= 64)};
        end else begin
            if (op == 2'b00) begin
                y = (a + b) % 64;
                c = (a + b) >= 64;
                v = ((sa + sb) > 31) || ((sa + sb) < -32);
            end else begin
                y = (a - b + 64) % 64;
                c = (a >= b);
                v = ((sa - sb) > 31) || ((sa - sb) < -32);
            end
            z = (y == 0);
            n = (y >= 32);
            if (op != 2'b11) exp_res = 12'(y);
            exp_flags = {z, n, c, v};
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic sel_exec, output logic busy_ok);
        @(negedge clk);
        start = 1'b1; op_i = op; opa = a; opb = b;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1; busy_ok = 1'b1; sel_exec = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (c == 1) sel_exec = add_sel;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; op_i = 2'b10; opa = 6'd5; opb = 6'd9;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL reset_busy_done got %b want 00", {busy, done});
        end
        checks++;
        if (res !== '0 || flags !== 4'b0) begin
            errors++; $display("FAIL reset_res_flags got %h/%b want 0/0", res, flags);
        end
        checks++;
        if ({add_sel, add_a, add_b} !== '0) begin
            errors++; $display("FAIL reset_adder got %b/%h/%h want 0", add_sel, add_a, add_b);
        end
        rst = 1'b0;
        exp_res = '0; exp_flags = '0;
    endtask

    task automatic test_add_sub();
        int lat; logic sel, bok;
        run_op(2'b00, 6'd20, 6'd15, lat, sel, bok);
        model(2'b00, 20, 15);
        checks++;
        if (lat !== 2 || !bok) begin
            errors++; $display("FAIL add_latency got %0d busy_ok=%b want 2/1", lat, bok);
        end
        checks++;
        if (res !== 12'b000000_100011 || flags !== 4'b0101) begin
            errors++; $display("FAIL add_20_15 got %b/%b want 000000100011/0101", res, flags);
        end
        run_op(2'b01, 6'd30, 6'd15, lat, sel, bok);
        model(2'b01, 30, 15);
        checks++;
        if (res !== exp_res || flags !== exp_flags || sel !== 1'b1 || lat !== 2) begin
            errors++; $display("FAIL sub_30_15 got %b/%b sel=%b lat=%0d want %b/%b sel=1 lat=2",
                               res, flags, sel, lat, exp_res, exp_flags);
        end
        run_op(2'b01, 6'd15, 6'd30, lat, sel, bok);
        model(2'b01, 15, 30);
        checks++;
        if (res !== exp_res || flags !== exp_flags) begin
            errors++; $display("FAIL sub_15_30 got %b/%b want %b/%b", res, flags, exp_res, exp_flags);
        end
    endtask

    task automatic test_mul_ignore_start();
        int ndone, first;
        ndone = 0; first = -1;
        @(negedge clk);
        start = 1'b1; op_i = 2'b10; opa = 6'd13; opb = 6'd11;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 3) begin
                start = 1'b1; op_i = 2'b00; opa = 6'd1; opb = 6'd2;
            end
            if (c == 4) start = 1'b0;
            if (done) begin
                ndone++;
                if (first < 0) first = c;
            end
        end
        model(2'b10, 13, 11);
        checks++;
        if (first !== 7 || ndone !== 1) begin
            errors++; $display("FAIL mul_timing first=%0d count=%0d want 7/1", first, ndone);
        end
        checks++;
        if (res !== exp_res || flags !== exp_flags) begin
            errors++; $display("FAIL mul_13_11 got %h/%b want %h/%b", res, flags, exp_res, exp_flags);
        end
    endtask

    task automatic test_mul_edges();
        int lat; logic sel, bok;
        run_op(2'b10, 6'd63, 6'd63, lat, sel, bok);
        model(2'b10, 63, 63);
        checks++;
        if (res !== 12'b111110_000001 || flags !== exp_flags || lat !== 7 || !bok) begin
            errors++; $display("FAIL mul_63_63 got %b/%b lat=%0d want 111110000001/%b lat=7",
                               res, flags, lat, exp_flags);
        end
        run_op(2'b10, 6'd0, 6'd45, lat, sel, bok);
        model(2'b10, 0, 45);
        checks++;
        if (res !== '0 || flags !== 4'b1000) begin
            errors++; $display("FAIL mul_0_45 got %h/%b want 0/1000", res, flags);
        end
    endtask

    task automatic test_cmp();
        int lat; logic sel, bok;
        run_op(2'b00, 6'd10, 6'd7, lat, sel, bok);
        model(2'b00, 10, 7);
        run_op(2'b11, 6'b100101, 6'b100101, lat, sel, bok);
        model(2'b11, 37, 37);
        checks++;
        if (res !== 12'd17 || flags !== 4'b1010 || lat !== 2) begin
            errors++; $display("FAIL cmp_equal got %h/%b lat=%0d want 011/1010 lat=2", res, flags, lat);
        end
    endtask

    task automatic test_midop_reset();
        int lat; logic sel, bok;
        @(negedge clk);
        start = 1'b1; op_i = 2'b10; opa = 6'd13; opb = 6'd11;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        exp_res = '0; exp_flags = '0;
        checks++;
        if ({busy, done} !== 2'b00 || res !== '0 || flags !== 4'b0) begin
            errors++; $display("FAIL midop_reset got busy=%b done=%b res=%h flags=%b want all 0",
                               busy, done, res, flags);
        end
        checks++;
        if ({add_sel, add_a, add_b} !== '0) begin
            errors++; $display("FAIL midop_adder got %b/%h/%h want 0", add_sel, add_a, add_b);
        end
        run_op(2'b00, 6'd20, 6'd15, lat, sel, bok);
        model(2'b00, 20, 15);
        checks++;
        if (lat !== 2 || res !== exp_res || flags !== exp_flags) begin
            errors++; $display("FAIL post_reset_add got %h/%b lat=%0d want %h/%b lat=2",
                               res, flags, lat, exp_res, exp_flags);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] mask, want;
        mask = '0;
        want = 16'b0000_0000_0010_0100;
        @(negedge clk);
        start = 1'b1; op_i = 2'b00; opa = 6'd3; opb = 6'd4;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                opa = 6'd50; opb = 6'd40;
            end
            if (c == 4) start = 1'b0;
            if (done) mask[c] = 1'b1;
        end
        model(2'b00, 3, 4);
        model(2'b00, 50, 40);
        checks++;
        if (mask !== want) begin
            errors++; $display("FAIL back_to_back_done got %b want %b", mask, want);
        end
        checks++;
        if (res !== exp_res || flags !== exp_flags) begin
            errors++; $display("FAIL back_to_back_res got %h/%b want %h/%b", res, flags, exp_res, exp_flags);
        end
    endtask

    task automatic test_random();
        int lat; logic sel, bok;
        logic [1:0] op;
        logic [W-1:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = 6'($urandom_range(0, 63));
            b  = 6'($urandom_range(0, 63));
            run_op(op, a, b, lat, sel, bok);
            model(op, int'(a), int'(b));
            checks++;
            if (res !== exp_res || flags !== exp_flags || !bok ||
                lat !== ((op == 2'b10) ? 7 : 2)) begin
                errors++; $display("FAIL random_%0d op=%b a=%0d b=%0d got %h/%b lat=%0d want %h/%b",
                                   i, op, a, b, res, flags, lat, exp_res, exp_flags);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_i = 2'b00; opa = '0; opb = '0;
        exp_res = '0; exp_flags = '0;
        test_reset();
        test_add_sub();
        test_mul_ignore_start();
        test_mul_edges();
        test_cmp();
        test_midop_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
